// File: rtl/testcore_oci_dct_pkg.sv
// Shared types and defaults for the OCI trace packing controller.
package testcore_oci_dct_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } dct_state_e;

  localparam int DEF_ITEM_W  = 6;
  localparam int DEF_SLOTS   = 5;
  localparam int DEF_TIMEOUT = 64;
  localparam int WORD_W      = 30;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/testcore_oci_dct_timer.sv
// Idle counter: fires on the TIMEOUT-th consecutive idle cycle of a partly filled buffer.
module testcore_oci_dct_timer
  import testcore_oci_dct_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Any non-idle cycle (an accept, or leaving FILL) restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_idle) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = i_idle && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/testcore_nios2_gen2_0_oci_dct_ctrl.sv
// Packs trace items into 30-bit words and flushes a partial word on end of test.
// Optional idle-timeout flush is built when DCT_TIMEOUT_EN is defined.
module testcore_nios2_gen2_0_oci_dct_ctrl
  import testcore_oci_dct_pkg::*;
#(
  parameter int ITEM_W  = DEF_ITEM_W,
  parameter int SLOTS   = DEF_SLOTS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              item_valid,
  output logic              item_ready,
  input  logic [ITEM_W-1:0] item_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic [WORD_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  input  logic              test_ending,
  output logic              test_has_ended
);

  dct_state_e        r_state;
  logic [WORD_W-1:0] r_buffer;
  logic [CNT_W-1:0]  r_count;
  logic              r_end;
  logic              r_item_ready;
  logic              r_out_valid;
  logic              r_done;

  logic [WORD_W-1:0] w_ins_buf;
  logic [CNT_W-1:0]  w_ins_cnt;
  logic [CNT_W-1:0]  w_eff_cnt;
  logic              w_accept;
  logic              w_end;
  logic              w_full;
  logic              w_timeout;

  assign w_accept  = item_valid && r_item_ready;
  assign w_end     = r_end || test_ending;
  assign w_ins_cnt = r_count + CNT_W'(1);
  assign w_eff_cnt = w_accept ? w_ins_cnt : r_count;
  assign w_full    = w_accept && (w_ins_cnt == CNT_W'(SLOTS));

  always_comb begin
    w_ins_buf = r_buffer;
    for (int s = 0; s < SLOTS; s++) begin
      if (r_count == CNT_W'(s)) w_ins_buf[s*ITEM_W +: ITEM_W] = item_data;
    end
  end

`ifdef DCT_TIMEOUT_EN
  logic w_idle;
  assign w_idle = (r_state == ST_FILL) && (r_count != '0) && !w_accept;

  testcore_oci_dct_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .i_idle   (w_idle),
    .o_expire (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Outputs are registered alongside the state so they follow the next-state choice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_FILL;
      r_buffer     <= '0;
      r_count      <= '0;
      r_end        <= 1'b0;
      r_item_ready <= 1'b1;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_FILL: begin
          if (test_ending) r_end <= 1'b1;
          if (w_accept) begin
            r_buffer <= w_ins_buf;
            r_count  <= w_ins_cnt;
          end
          if (w_end && (w_eff_cnt == '0)) begin
            r_state      <= ST_DONE;
            r_item_ready <= 1'b0;
            r_done       <= 1'b1;
          end else if (w_end || w_full || w_timeout) begin
            r_state      <= ST_EMIT;
            r_item_ready <= 1'b0;
            r_out_valid  <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (test_ending) r_end <= 1'b1;
          if (out_ready) begin
            r_buffer    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            if (w_end) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= ST_FILL;
              r_item_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state      <= ST_DONE;
          r_item_ready <= 1'b0;
          r_out_valid  <= 1'b0;
          r_done       <= 1'b1;
        end
      endcase
    end
  end

  assign item_ready     = r_item_ready;
  assign out_valid      = r_out_valid;
  assign out_data       = r_buffer;
  assign out_count      = r_count;
  assign dct_buffer     = r_buffer;
  assign dct_count      = r_count;
  assign test_has_ended = r_done;

endmodule

// File: tb/tb_testcore_nios2_gen2_0_oci_dct_ctrl.sv
// Directed-vector bench for the OCI trace packing controller.
module tb_testcore_nios2_gen2_0_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        item_valid;
  logic        item_ready;
  logic [5:0]  item_data;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_data;
  logic [3:0]  out_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        iv;
    logic [5:0]  d;
    logic        ordy;
    logic        te;
    logic        e_rdy;
    logic        e_ov;
    logic [29:0] e_data;
    logic [3:0]  e_cnt;
    logic        e_done;
  } vec_t;

  vec_t vecs[7];

  testcore_nios2_gen2_0_oci_dct_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .item_valid     (item_valid),
    .item_ready     (item_ready),
    .item_data      (item_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_count      (out_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    item_valid  = 1'b0;
    item_data   = '0;
    out_ready   = 1'b0;
    test_ending = 1'b0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [5:0] d, input logic ordy, input logic te);
    item_valid  = iv;
    item_data   = d;
    out_ready   = ordy;
    test_ending = te;
  endtask

  initial begin
    vecs[0] = '{1'b1, 6'h01, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0,         4'd0, 1'b0};
    vecs[1] = '{1'b1, 6'h02, 1'b1, 1'b0, 1'b1, 1'b0, 30'h1,         4'd1, 1'b0};
    vecs[2] = '{1'b1, 6'h03, 1'b1, 1'b0, 1'b1, 1'b0, 30'h81,        4'd2, 1'b0};
    vecs[3] = '{1'b1, 6'h04, 1'b1, 1'b0, 1'b1, 1'b0, 30'h3081,      4'd3, 1'b0};
    vecs[4] = '{1'b1, 6'h05, 1'b1, 1'b0, 1'b1, 1'b0, 30'h103081,    4'd4, 1'b0};
    vecs[5] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 30'h05103081,  4'd5, 1'b0};
    vecs[6] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0,         4'd0, 1'b0};

    // Five-item word with immediate acceptance; row 0 also covers the reset state.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].te);
      chk($sformatf("v%0d_item_ready", i), 32'(item_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_dct_buffer", i), 32'(dct_buffer), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_out_count", i), 32'(out_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_dct_count", i), 32'(dct_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_ended", i), 32'(test_has_ended), 32'(vecs[i].e_done));
      tick();
    end

    // Backpressure: full word held for 10 cycles with out_ready low.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'(6'h10 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 6'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h144D2450);
      chk("bp_item_ready", 32'(item_ready), 32'd0);
      tick();
    end
    drive(1'b0, 6'h00, 1'b1, 1'b0);
    chk("bp_rel_out_count", 32'(out_count), 32'd5);
    tick();
    chk("bp_after_out_valid", 32'(out_valid), 32'd0);
    chk("bp_after_item_ready", 32'(item_ready), 32'd1);
    chk("bp_after_count", 32'(dct_count), 32'd0);

    // Partial flush on a test_ending pulse.
    drive(1'b1, 6'h3F, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'h2A, 1'b0, 1'b0);
    tick();
    drive(1'b0, 6'h00, 1'b0, 1'b1);
    chk("te_pre_count", 32'(dct_count), 32'd2);
    tick();
    drive(1'b0, 6'h00, 1'b0, 1'b0);
    chk("te_out_valid", 32'(out_valid), 32'd1);
    chk("te_out_data", 32'(out_data), 32'hABF);
    chk("te_out_count", 32'(out_count), 32'd2);
    chk("te_item_ready", 32'(item_ready), 32'd0);
    tick();
    out_ready = 1'b1;
    chk("te_hold_valid", 32'(out_valid), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'(i), 1'b1, i[0]);
      chk("te_done", 32'(test_has_ended), 32'd1);
      chk("te_done_ready", 32'(item_ready), 32'd0);
      chk("te_done_valid", 32'(out_valid), 32'd0);
      tick();
    end

    // test_ending with an empty buffer goes straight to DONE.
    do_reset();
    drive(1'b0, 6'h00, 1'b1, 1'b1);
    tick();
    drive(1'b0, 6'h00, 1'b1, 1'b0);
    chk("empty_done", 32'(test_has_ended), 32'd1);
    chk("empty_ready", 32'(item_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("empty_no_valid", 32'(out_valid), 32'd0);
      tick();
    end

    // Item accepted in the same cycle as test_ending is packed into the flush.
    do_reset();
    drive(1'b1, 6'h07, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'h09, 1'b0, 1'b1);
    chk("same_ready", 32'(item_ready), 32'd1);
    tick();
    drive(1'b0, 6'h00, 1'b1, 1'b0);
    chk("same_out_valid", 32'(out_valid), 32'd1);
    chk("same_out_data", 32'(out_data), 32'h247);
    chk("same_out_count", 32'(out_count), 32'd2);
    tick();
    chk("same_done", 32'(test_has_ended), 32'd1);
    chk("same_done_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of EMIT discards the pending word.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'(i + 1), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 6'h00, 1'b0, 1'b0);
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_count", 32'(dct_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_post_valid", 32'(out_valid), 32'd0);
      chk("rst_post_done", 32'(test_has_ended), 32'd0);
      chk("rst_post_ready", 32'(item_ready), 32'd1);
      chk("rst_post_buf", 32'(dct_buffer), 32'd0);
      tick();
    end

`ifdef DCT_TIMEOUT_EN
    // One item then idle: the partial word appears after 64 idle cycles.
    begin
      int idle_n;
      bit seen;
      do_reset();
      drive(1'b1, 6'h15, 1'b0, 1'b0);
      tick();
      drive(1'b0, 6'h00, 1'b0, 1'b0);
      idle_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        if (out_valid) seen = 1'b1;
        else begin
          idle_n++;
          tick();
        end
      end
      chk("tmo_seen", 32'(seen), 32'd1);
      chk("tmo_idle_cycles", 32'(idle_n), 32'd64);
      chk("tmo_out_count", 32'(out_count), 32'd1);
      chk("tmo_out_data", 32'(out_data), 32'h15);
      #1 reset = 1'b1;
      #1;
      chk("tmo_rst_valid", 32'(out_valid), 32'd0);
      chk("tmo_rst_done", 32'(test_has_ended), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
